// File: rtl/mac_vector_accum.sv
// Vector multiply-accumulate: LANES independent MACs fed by paired act/weight beat streams,
// optionally seeded from a psum vector, with per-lane requantisation on the way out.
module mac_vector_accum #(
   parameter int unsigned LANES = 16,
   parameter int unsigned ACT_W = 8,
   parameter int unsigned WGT_W = 8,
   parameter int unsigned PS_W  = 32,
   parameter int unsigned OUT_W = 32,
   parameter int unsigned K_MAX = 1024,
   parameter int unsigned KW    = $clog2(K_MAX + 1),
   parameter int unsigned SW    = $clog2(PS_W)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clk_en,
   input  logic [LANES*ACT_W-1:0] act_vec,
   input  logic                   act_vld,
   output logic                   act_rdy,
   input  logic [LANES*WGT_W-1:0] wgt_vec,
   input  logic                   wgt_vld,
   output logic                   wgt_rdy,
   input  logic [LANES*PS_W-1:0]  psum_vec_in,
   input  logic                   psum_vld_in,
   output logic                   psum_rdy_in,
   output logic [LANES*OUT_W-1:0] psum_vec_out,
   output logic                   psum_vld_out,
   input  logic                   psum_rdy_out,
   input  logic [KW-1:0]          k_len,
   input  logic                   psum_en,
   input  logic                   act_signed,
   input  logic [SW-1:0]          shift_amount,
   input  logic [1:0]             round_mode,
   input  logic                   sat_en,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   acc_overflow
);

   localparam int unsigned PW = ACT_W + 1 + WGT_W;

   typedef enum logic [1:0] {StIdle, StLoad, StAccum, StDrain} state_e;

   state_e                 state_q, state_d;
   logic [LANES*PS_W-1:0]  acc_q, acc_d;
   logic [KW-1:0]          cnt_q, cnt_d, k_len_q, k_len_d, k_clamp;
   logic                   act_signed_q, act_signed_d, sat_q, sat_d;
   logic [SW-1:0]          shift_q, shift_d;
   logic [1:0]             mode_q, mode_d;
   logic                   ovf_q, ovf_d, vld_q, vld_d, done_q, done_d;
   logic [LANES*OUT_W-1:0] out_q, out_d;
   logic [LANES*PS_W-1:0]  mac_sum;
   logic [LANES-1:0]       lane_ovf;
   logic                   enter_drain;

   // Returns {signed-overflow flag, wrapped sum}.
   function automatic logic [PS_W:0] mac_lane(input logic [PS_W-1:0]  acc,
                                              input logic [ACT_W-1:0] a,
                                              input logic [WGT_W-1:0] w,
                                              input logic             a_signed);
      logic signed [ACT_W:0]  a_ext;
      logic signed [PW-1:0]   prod;
      logic        [PS_W-1:0] p_ext, sum;
      a_ext = signed'({a_signed & a[ACT_W-1], a});
      prod  = PW'(a_ext) * PW'(signed'(w));
      p_ext = {{(PS_W-PW){prod[PW-1]}}, prod};
      sum   = acc + p_ext;
      return {(acc[PS_W-1] == p_ext[PS_W-1]) && (sum[PS_W-1] != acc[PS_W-1]), sum};
   endfunction

   // One guard bit above PS_W keeps half-up rounding of the most positive value exact.
   function automatic logic [OUT_W-1:0] requant(input logic [PS_W-1:0] acc,
                                                input logic [SW-1:0]   sh,
                                                input logic [1:0]      mode,
                                                input logic            sat);
      logic signed [PS_W:0] one, a, q, r, half, y, hi, lo;
      one  = (PS_W+1)'(1);
      a    = signed'({acc[PS_W-1], acc});
      q    = '0;
      r    = '0;
      half = '0;
      y    = a;
      if (sh != '0) begin
         q    = a >>> sh;
         r    = a - (q <<< sh);
         half = one <<< (sh - SW'(1));
         if (mode == 2'd1) begin
            y = (r >= half) ? q + one : q;
         end else if (mode == 2'd2) begin
            y = ((r > half) || ((r == half) && q[0])) ? q + one : q;
         end else begin
            y = q;
         end
      end
      hi = (one <<< (OUT_W - 1)) - one;
      lo = -(one <<< (OUT_W - 1));
      if (sat) begin
         if (y > hi) y = hi;
         else if (y < lo) y = lo;
      end
      return y[OUT_W-1:0];
   endfunction

   assign act_rdy      = clk_en & (state_q == StAccum) & act_vld & wgt_vld;
   assign wgt_rdy      = act_rdy;
   assign psum_rdy_in  = clk_en & (state_q == StLoad);
   assign busy         = (state_q != StIdle);
   assign done         = done_q;
   assign acc_overflow = ovf_q;
   assign psum_vec_out = out_q;
   assign psum_vld_out = vld_q;
   assign k_clamp      = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;

   always_comb begin
      mac_sum  = '0;
      lane_ovf = '0;
      for (int i = 0; i < LANES; i++) begin
         {lane_ovf[i], mac_sum[i*PS_W +: PS_W]} = mac_lane(acc_q[i*PS_W +: PS_W],
                                                           act_vec[i*ACT_W +: ACT_W],
                                                           wgt_vec[i*WGT_W +: WGT_W],
                                                           act_signed_q);
      end
   end

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      k_len_d      = k_len_q;
      act_signed_d = act_signed_q;
      shift_d      = shift_q;
      mode_d       = mode_q;
      sat_d        = sat_q;
      ovf_d        = ovf_q;
      vld_d        = vld_q;
      done_d       = done_q;
      enter_drain  = 1'b0;
      if (clk_en) begin
         done_d = 1'b0;
         unique case (state_q)
            StIdle: begin
               // done_q marks the cycle right after a handshake, where start is ignored.
               if (start && !done_q) begin
                  k_len_d      = k_clamp;
                  act_signed_d = act_signed;
                  shift_d      = shift_amount;
                  mode_d       = round_mode;
                  sat_d        = sat_en;
                  ovf_d        = 1'b0;
                  cnt_d        = '0;
                  acc_d        = '0;
                  if (psum_en) begin
                     state_d = StLoad;
                  end else if (k_clamp == '0) begin
                     state_d     = StDrain;
                     vld_d       = 1'b1;
                     enter_drain = 1'b1;
                  end else begin
                     state_d = StAccum;
                  end
               end
            end
            StLoad: begin
               if (psum_vld_in) begin
                  acc_d = psum_vec_in;
                  if (k_len_q == '0) begin
                     state_d     = StDrain;
                     vld_d       = 1'b1;
                     enter_drain = 1'b1;
                  end else begin
                     state_d = StAccum;
                  end
               end
            end
            StAccum: begin
               if (act_vld && wgt_vld) begin
                  acc_d = mac_sum;
                  ovf_d = ovf_q | (|lane_ovf);
                  cnt_d = cnt_q + KW'(1);
                  if (cnt_d == k_len_q) begin
                     state_d     = StDrain;
                     vld_d       = 1'b1;
                     enter_drain = 1'b1;
                  end
               end
            end
            StDrain: begin
               if (psum_rdy_out) begin
                  state_d = StIdle;
                  vld_d   = 1'b0;
                  done_d  = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      out_d = out_q;
      if (enter_drain) begin
         for (int i = 0; i < LANES; i++) begin
            out_d[i*OUT_W +: OUT_W] = requant(acc_d[i*PS_W +: PS_W], shift_q, mode_q, sat_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         acc_q        <= '0;
         cnt_q        <= '0;
         k_len_q      <= '0;
         act_signed_q <= 1'b0;
         shift_q      <= '0;
         mode_q       <= '0;
         sat_q        <= 1'b0;
         ovf_q        <= 1'b0;
         vld_q        <= 1'b0;
         done_q       <= 1'b0;
         out_q        <= '0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         k_len_q      <= k_len_d;
         act_signed_q <= act_signed_d;
         shift_q      <= shift_d;
         mode_q       <= mode_d;
         sat_q        <= sat_d;
         ovf_q        <= ovf_d;
         vld_q        <= vld_d;
         done_q       <= done_d;
         out_q        <= out_d;
      end
   end

endmodule

// File: tb/tb_mac_vector_accum.sv
// Directed bench for mac_vector_accum: a 32-bit-output instance and an 8-bit-output instance
// share every input so saturation can be checked alongside the full-width results.
module tb_mac_vector_accum;

   logic         clk = 1'b0;
   logic         rst, clk_en, start, psum_en, act_signed, sat_en;
   logic [10:0]  k_len;
   logic [4:0]   shift_amount;
   logic [1:0]   round_mode;
   logic [31:0]  act_vec, wgt_vec;
   logic         act_vld, wgt_vld, psum_vld_in, psum_rdy_out;
   logic [127:0] psum_vec_in, psum_vec_out;
   logic         act_rdy, wgt_rdy, psum_rdy_in, psum_vld_out, busy, done, acc_overflow;
   logic [31:0]  out8_vec;
   logic         act_rdy8, wgt_rdy8, psum_rdy_in8, psum_vld_out8, busy8, done8, acc_overflow8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mac_vector_accum #(.LANES(4), .OUT_W(32)) u_dut (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .act_vec(act_vec), .act_vld(act_vld), .act_rdy(act_rdy),
      .wgt_vec(wgt_vec), .wgt_vld(wgt_vld), .wgt_rdy(wgt_rdy),
      .psum_vec_in(psum_vec_in), .psum_vld_in(psum_vld_in), .psum_rdy_in(psum_rdy_in),
      .psum_vec_out(psum_vec_out), .psum_vld_out(psum_vld_out), .psum_rdy_out(psum_rdy_out),
      .k_len(k_len), .psum_en(psum_en), .act_signed(act_signed),
      .shift_amount(shift_amount), .round_mode(round_mode), .sat_en(sat_en),
      .start(start), .busy(busy), .done(done), .acc_overflow(acc_overflow)
   );

   mac_vector_accum #(.LANES(4), .OUT_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .act_vec(act_vec), .act_vld(act_vld), .act_rdy(act_rdy8),
      .wgt_vec(wgt_vec), .wgt_vld(wgt_vld), .wgt_rdy(wgt_rdy8),
      .psum_vec_in(psum_vec_in), .psum_vld_in(psum_vld_in), .psum_rdy_in(psum_rdy_in8),
      .psum_vec_out(out8_vec), .psum_vld_out(psum_vld_out8), .psum_rdy_out(psum_rdy_out),
      .k_len(k_len), .psum_en(psum_en), .act_signed(act_signed),
      .shift_amount(shift_amount), .round_mode(round_mode), .sat_en(sat_en),
      .start(start), .busy(busy8), .done(done8), .acc_overflow(acc_overflow8)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_lanes(input string tag, input logic [127:0] exp, input logic [31:0] exp8);
      for (int i = 0; i < 4; i++) begin
         check_eq({tag, "_lane32"}, psum_vec_out[i*32 +: 32], exp[i*32 +: 32]);
         check_eq({tag, "_lane8"}, out8_vec[i*8 +: 8], exp8[i*8 +: 8]);
      end
   endtask

   // Full pass: start, optional psum load, k beats, result check, output handshake.
   task automatic run_pass(input string tag, input int k, input bit pe, input logic [127:0] ps,
                           input bit as, input logic [4:0] sh, input logic [1:0] rm,
                           input bit sat, input logic [31:0] a, input logic [31:0] w,
                           input logic [127:0] exp, input logic [31:0] exp8, input bit exp_ovf);
      int n;
      k_len = 11'(k); psum_en = pe; act_signed = as; shift_amount = sh;
      round_mode = rm; sat_en = sat; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check_eq({tag, "_busy"}, busy, 1);
      check_eq({tag, "_ovf_clr"}, acc_overflow, 0);
      if (pe) begin
         psum_vec_in = ps; psum_vld_in = 1'b1; n = 0;
         while (!psum_rdy_in && n < 50) begin @(negedge clk); #1; n++; end
         check_eq({tag, "_load_rdy"}, psum_rdy_in, 1);
         @(negedge clk);
         psum_vld_in = 1'b0;
      end
      act_vec = a; wgt_vec = w;
      for (int b = 0; b < k; b++) begin
         act_vld = 1'b1; wgt_vld = 1'b1; n = 0;
         #1;
         while (!act_rdy && n < 50) begin @(negedge clk); #1; n++; end
         check_eq({tag, "_beat_rdy"}, act_rdy, 1);
         if (b == k - 1) check_eq({tag, "_vld_early"}, psum_vld_out, 0);
         @(negedge clk);
      end
      act_vld = 1'b0; wgt_vld = 1'b0;
      #1;
      check_eq({tag, "_vld_lat"}, psum_vld_out, 1);
      n = 0;
      while (!psum_vld_out && n < 50) begin @(negedge clk); #1; n++; end
      check_lanes(tag, exp, exp8);
      check_eq({tag, "_ovf"}, acc_overflow, 64'(exp_ovf));
      psum_rdy_out = 1'b1;
      @(negedge clk);
      psum_rdy_out = 1'b0;
      #1;
      check_eq({tag, "_done"}, done, 1);
      check_eq({tag, "_vld_clr"}, psum_vld_out, 0);
      check_eq({tag, "_idle"}, busy, 0);
      @(negedge clk);
      #1;
      check_eq({tag, "_done_1cyc"}, done, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, bad, beats, unstable, extra;
      rst = 1'b1; clk_en = 1'b0; start = 1'b0; psum_en = 1'b0; act_signed = 1'b0;
      sat_en = 1'b0; k_len = '0; shift_amount = '0; round_mode = '0;
      act_vec = '0; wgt_vec = '0; act_vld = 1'b0; wgt_vld = 1'b0;
      psum_vec_in = '0; psum_vld_in = 1'b0; psum_rdy_out = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_vld", psum_vld_out, 0);
      check_eq("rst_vec", psum_vec_out[63:0], 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_ovf", acc_overflow, 0);
      check_eq("rst_rdy", {act_rdy, wgt_rdy, psum_rdy_in}, 0);
      rst = 1'b0; clk_en = 1'b1;
      @(negedge clk);

      // 2 * -3 over three beats
      run_pass("basic", 3, 0, '0, 0, 5'd0, 2'd0, 0, {4{8'h02}}, {4{8'hFD}},
               {4{32'hFFFFFFEE}}, {4{8'hEE}}, 0);
      run_pass("psum_s", 1, 1, {4{32'd100}}, 1, 5'd0, 2'd0, 0, {4{8'hFF}}, {4{8'h01}},
               {4{32'd99}}, {4{8'h63}}, 0);
      run_pass("psum_u", 1, 1, {4{32'd100}}, 0, 5'd0, 2'd0, 0, {4{8'hFF}}, {4{8'h01}},
               {4{32'd355}}, {4{8'h63}}, 0);
      run_pass("lanes", 2, 1, {32'd40, 32'd30, 32'd20, 32'd10}, 1, 5'd0, 2'd0, 1,
               {8'h80, 8'h10, 8'h05, 8'h01}, {8'h02, 8'hFF, 8'h7F, 8'h80},
               {32'hFFFFFE28, 32'hFFFFFFFE, 32'h0000050A, 32'hFFFFFF0A},
               {8'h80, 8'hFE, 8'h7F, 8'h80}, 0);
      run_pass("k0", 0, 0, '0, 0, 5'd0, 2'd0, 0, {4{8'h05}}, {4{8'h05}}, '0, '0, 0);
      run_pass("wrap", 1, 1, {4{32'h7FFFFFF0}}, 1, 5'd0, 2'd0, 0, {4{8'h7F}}, {4{8'h7F}},
               {4{32'h80003EF1}}, {4{8'hF1}}, 1);
      check_eq("ovf_sticky", acc_overflow, 1);
      // Reset must win over a low clk_en.
      clk_en = 1'b0; rst = 1'b1;
      @(negedge clk);
      #1;
      check_eq("rst_noen_ovf", acc_overflow, 0);
      check_eq("rst_noen_vec", |psum_vec_out, 0);
      rst = 1'b0; clk_en = 1'b1;

      run_pass("rnd_m0", 0, 1, {4{-32'sd5}}, 0, 5'd1, 2'd0, 0, '0, '0,
               {4{32'hFFFFFFFD}}, {4{8'hFD}}, 0);
      run_pass("rnd_m1", 0, 1, {4{-32'sd5}}, 0, 5'd1, 2'd1, 0, '0, '0,
               {4{32'hFFFFFFFE}}, {4{8'hFE}}, 0);
      run_pass("rnd_m2", 0, 1, {4{-32'sd5}}, 0, 5'd1, 2'd2, 0, '0, '0,
               {4{32'hFFFFFFFE}}, {4{8'hFE}}, 0);
      run_pass("rnd_m3", 0, 1, {4{-32'sd5}}, 0, 5'd1, 2'd3, 0, '0, '0,
               {4{32'hFFFFFFFD}}, {4{8'hFD}}, 0);
      run_pass("rne_even", 0, 1, {4{-32'sd7}}, 0, 5'd1, 2'd2, 0, '0, '0,
               {4{32'hFFFFFFFC}}, {4{8'hFC}}, 0);
      run_pass("rne_10", 0, 1, {4{32'd10}}, 0, 5'd2, 2'd2, 0, '0, '0,
               {4{32'd2}}, {4{8'd2}}, 0);
      run_pass("rhu_10", 0, 1, {4{32'd10}}, 0, 5'd2, 2'd1, 0, '0, '0,
               {4{32'd3}}, {4{8'd3}}, 0);
      run_pass("rne_6", 0, 1, {4{32'd6}}, 0, 5'd2, 2'd2, 0, '0, '0,
               {4{32'd2}}, {4{8'd2}}, 0);
      run_pass("sat_pos", 0, 1, {4{32'd300}}, 0, 5'd0, 2'd0, 1, '0, '0,
               {4{32'd300}}, {4{8'h7F}}, 0);
      run_pass("sat_neg", 0, 1, {4{-32'sd300}}, 0, 5'd0, 2'd0, 1, '0, '0,
               {4{32'hFFFFFED4}}, {4{8'h80}}, 0);
      run_pass("nosat", 0, 1, {4{32'd300}}, 0, 5'd0, 2'd0, 0, '0, '0,
               {4{32'd300}}, {4{8'h2C}}, 0);

      // Stalls: act alone, clk_en toggling, output backpressure, ignored starts.
      k_len = 11'd2; psum_en = 1'b0; act_signed = 1'b0; shift_amount = '0;
      round_mode = '0; sat_en = 1'b0; act_vec = {4{8'd3}}; wgt_vec = {4{8'd4}};
      start = 1'b1;
      @(negedge clk);
      k_len = 11'd1; psum_en = 1'b1;
      act_vld = 1'b1; wgt_vld = 1'b0; bad = 0;
      repeat (5) begin #1; if (act_rdy || wgt_rdy) bad++; @(negedge clk); end
      start = 1'b0;
      check_eq("act_alone", bad, 0);
      wgt_vld = 1'b1; beats = 0; bad = 0; n = 0;
      while (beats < 2 && n < 100) begin
         clk_en = 1'($urandom_range(0, 1));
         #1;
         if (!clk_en && act_rdy) bad++;
         if (act_rdy) beats++;
         @(negedge clk);
         n++;
      end
      act_vld = 1'b0; wgt_vld = 1'b0; clk_en = 1'b1;
      check_eq("en_gate_rdy", bad, 0);
      check_eq("stall_beats", beats, 2);
      #1;
      check_eq("stall_vld", psum_vld_out, 1);
      check_lanes("stall", {4{32'd24}}, {4{8'd24}});
      clk_en = 1'b0; psum_rdy_out = 1'b1;
      @(negedge clk);
      #1;
      check_eq("freeze_vld", psum_vld_out, 1);
      check_eq("freeze_done", done, 0);
      unstable = 0; n = 0;
      while (!done && n < 200) begin
         psum_rdy_out = ($urandom_range(0, 2) == 0);
         clk_en = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         #1;
         if (psum_vld_out && (psum_vec_out != {4{32'd24}})) unstable++;
         n++;
      end
      check_eq("stall_done", done, 1);
      check_eq("stall_stable", unstable, 0);
      clk_en = 1'b1; psum_rdy_out = 1'b0; k_len = '0; psum_en = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check_eq("start_in_done", busy, 0);
      extra = 0;
      repeat (5) begin if (done) extra++; @(negedge clk); #1; end
      check_eq("single_done", extra, 0);

      // Reset during beat 2 of 4.
      k_len = 11'd4; psum_en = 1'b0; act_vec = {4{8'd1}}; wgt_vec = {4{8'd1}}; start = 1'b1;
      @(negedge clk);
      start = 1'b0; act_vld = 1'b1; wgt_vld = 1'b1;
      #1;
      check_eq("rst_mid_b1", act_rdy, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_eq("rst_mid_vld", psum_vld_out, 0);
      check_eq("rst_mid_vec", |psum_vec_out, 0);
      check_eq("rst_mid_busy", busy, 0);
      check_eq("rst_mid_rdy", {act_rdy, wgt_rdy, psum_rdy_in}, 0);
      rst = 1'b0; act_vld = 1'b0; wgt_vld = 1'b0; extra = 0;
      repeat (4) begin @(negedge clk); #1; if (done) extra++; end
      check_eq("rst_mid_nodone", extra, 0);
      run_pass("after_rst", 2, 0, '0, 0, 5'd0, 2'd0, 0, {4{8'd5}}, {4{8'hFE}},
               {4{-32'sd20}}, {4{8'hEC}}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_vector_accum.md
MAC_VECTOR_ACCUM -- requirements
Module: mac_vector_accum

Interface
REQ-001 SHALL have parameter LANES, default 16: number of independent MAC lanes.
REQ-002 SHALL have parameter ACT_W, default 8: activation width per lane.
REQ-003 SHALL have parameter WGT_W, default 8: signed weight width per lane.
REQ-004 SHALL have parameter PS_W, default 32: signed accumulator and psum-in width per lane.
REQ-005 SHALL have parameter OUT_W, default 32: output width per lane, with OUT_W <= PS_W.
REQ-006 SHALL have parameter K_MAX, default 1024: maximum beats per pass. KW = $clog2(K_MAX+1). SW = $clog2(PS_W).
REQ-007 SHALL have port clk, in, 1: sole clock, rising edge.
REQ-008 SHALL have port rst, in, 1: synchronous active-high reset.
REQ-009 SHALL have port clk_en, in, 1: global advance enable.
REQ-010 SHALL have ports act_vec in LANES*ACT_W, act_vld in 1, act_rdy out 1: activation beat stream; lane i at bits [i*ACT_W +: ACT_W].
REQ-011 SHALL have ports wgt_vec in LANES*WGT_W, wgt_vld in 1, wgt_rdy out 1: weight beat stream, same lane packing.
REQ-012 SHALL have ports psum_vec_in in LANES*PS_W, psum_vld_in in 1, psum_rdy_in out 1: initial partial sums.
REQ-013 SHALL have ports psum_vec_out out LANES*OUT_W, psum_vld_out out 1, psum_rdy_out in 1: result vector.
REQ-014 SHALL have config inputs sampled at start: k_len in KW (beat count), psum_en in 1, act_signed in 1, shift_amount in SW, round_mode in 2, sat_en in 1.
REQ-015 SHALL have port start, in, 1: pass request.
REQ-016 SHALL have status outputs busy, done, acc_overflow, each 1 bit.

Function
REQ-017 SHALL implement FSM IDLE -> (LOAD if psum_en else ACCUM) -> ACCUM -> DRAIN -> IDLE.
REQ-018 In IDLE, start=1 with clk_en=1 SHALL latch all config and clear acc_overflow. acc SHALL be cleared to 0 when entering ACCUM directly.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 k_len=0 SHALL go straight to DRAIN after LOAD, or from IDLE if psum_en=0. k_len > K_MAX SHALL be clamped to K_MAX.
REQ-021 LOAD: psum_rdy_in=1; on psum_vld_in, acc[i] = psum_vec_in lane i and the FSM SHALL move to ACCUM, or to DRAIN if k_len=0.
REQ-022 ACCUM beat handshake: act_rdy = wgt_rdy = clk_en & ACCUM & act_vld & wgt_vld. No beat SHALL be consumed from one stream without the other.
REQ-023 Per beat, each lane SHALL compute acc[i] += act[i]*wgt[i].
REQ-024 act SHALL be sign-extended if act_signed, else zero-extended. Weights are always signed. The product SHALL be sign-extended to PS_W.
REQ-025 The beat counter SHALL increment per beat; on beat k_len the FSM SHALL enter DRAIN.
REQ-026 On signed PS_W overflow of any lane add, the result SHALL wrap (two's complement) and acc_overflow SHALL set sticky until the next accepted start or reset.
REQ-027 Entering DRAIN SHALL register psum_vec_out; psum_vld_out SHALL be asserted the cycle after the last beat (one-cycle latency).
REQ-028 Requant per lane: shift_amount=0 SHALL pass acc unchanged. Otherwise y = acc >>> shift with round_mode 0 = truncate (floor), 1 = add 2^(shift-1) before shift (half-up), 2 = half-to-even, 3 = as 0.
REQ-029 sat_en=1 SHALL clamp y to the signed OUT_W range. sat_en=0 SHALL take the low OUT_W bits.
REQ-030 psum_vec_out and psum_vld_out SHALL remain stable until psum_rdy_out=1 with clk_en=1.
REQ-031 On the output handshake, done SHALL pulse high for exactly one cycle and the FSM SHALL return to IDLE. A start in the done cycle SHALL be ignored.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 clk_en=0 SHALL freeze all registers. act_rdy, wgt_rdy and psum_rdy_in SHALL be 0. psum_vld_out and its data SHALL hold, and psum_rdy_out SHALL NOT complete a transfer.
REQ-034 All ready outputs SHALL be combinational from state and input valids only, never from ready inputs.

Reset
REQ-035 rst=1 at a clock edge SHALL force IDLE and zero acc, counter, psum_vec_out, psum_vld_out, act_rdy, wgt_rdy, psum_rdy_in, busy, done and acc_overflow, regardless of clk_en.
REQ-036 rst mid-pass SHALL abandon the pass with no done pulse. The first start after reset release SHALL be accepted.

Verification
REQ-037 LANES=4, k_len=3, psum_en=0, act=2, wgt=-3 every beat, shift 0 -> psum_vec_out lanes = -18, vld one cycle after beat 3, done pulse on handshake.
REQ-038 psum_en=1, psum_in=100, k_len=1, act=0xFF with act_signed=1 then 0, wgt=1 -> outputs 99 and 355 respectively.
REQ-039 acc=0x7FFFFFF0 via psum_in, one beat 127*127 -> wrapped value output, acc_overflow=1 until next start.
REQ-040 acc=-5, shift=1: round_mode 0 -> -3, mode 1 -> -2, mode 2 -> -2; acc=300, OUT_W=8, sat_en=1 -> 127.
REQ-041 act_vld alone for 5 cycles, random psum_rdy_out stalls, clk_en toggling -> no beat consumed until wgt_vld, output held stable, exactly one done.
REQ-042 rst asserted during ACCUM beat 2 of 4 -> all outputs zero next cycle, no done; new start then completes normally.
